ghost_rng: RTL and testbench

- Parametrised pseudo-random source for ghost decision logic (scatter targets, frightened-mode turns, tie-breaks).
- Generalises the fixed 10-bit LFSR with:
  - configurable width and taps;
  - run-time seed load;
  - a request/response draw port that returns an unbiased value in [0, limit) by rejection sampling.
- Sits between the game-tick controller (free-run enable) and the ghost FSMs (draw requesters).

---
 rtl/ghost_rng_if.sv | 23 ++
 rtl/ghost_rng.sv | 109 ++++++++++
 tb/tb_ghost_rng.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ghost_rng_if.sv
// Draw-port bundle for ghost_rng: request/limit in, handshaked result out.
`timescale 1ns/1ps
interface ghost_rng_if #(
    parameter int OUT_W = 4
);
    logic             req;
    logic [OUT_W-1:0] limit;
    logic             busy;
    logic             valid;
    logic             ready;
    logic [OUT_W-1:0] rand_out;
    logic             fail;

    modport master (
        output req, limit, ready,
        input  busy, valid, rand_out, fail
    );

    modport slave (
        input  req, limit, ready,
        output busy, valid, rand_out, fail
    );
endinterface

// File: rtl/ghost_rng.sv
// Fibonacci LFSR with run-time seeding and a rejection-sampling draw port
// returning an unbiased value in [0, limit) for the ghost decision logic.
`timescale 1ns/1ps
module ghost_rng #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'h0001,
    parameter int               OUT_W     = 4,
    parameter int               MAX_TRIES = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state_q,
    ghost_rng_if.slave       drw
);
    localparam int             TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] r, r_step, seed_eff;
    logic [OUT_W-1:0] lim_q, lim_d, rand_q, rand_d, cand;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             fail_q, fail_d;
    logic             in_range;

    assign r_step   = {r[WIDTH-2:0], ^(r & TAPS)};
    // A zero seed would lock the LFSR, so it is replaced by the reset seed.
    assign seed_eff = (seed_in == '0) ? SEED : seed_in;
    assign cand     = r[OUT_W-1:0];
    assign in_range = (lim_q == '0) || (cand < lim_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r <= SEED;
        else if (seed_load)
            r <= seed_eff;
        else if (en || state == DRAW)
            r <= r_step;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            lim_q   <= '0;
            tries_q <= '0;
            rand_q  <= '0;
            fail_q  <= 1'b0;
        end else begin
            state   <= state_d;
            lim_q   <= lim_d;
            tries_q <= tries_d;
            rand_q  <= rand_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state;
        lim_d   = lim_q;
        tries_d = tries_q;
        rand_d  = rand_q;
        fail_d  = fail_q;
        case (state)
            IDLE: begin
                if (drw.req) begin
                    lim_d   = drw.limit;
                    tries_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                // A seed load replaces the candidate, so that cycle is not evaluated.
                if (!seed_load) begin
                    if (in_range) begin
                        rand_d  = cand;
                        fail_d  = 1'b0;
                        state_d = DONE;
                    end else if (tries_q == LAST_TRY) begin
                        rand_d  = '0;
                        fail_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                    end
                end
            end
            DONE: begin
                if (drw.ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_q      = r;
    assign drw.busy     = (state != IDLE);
    assign drw.valid    = (state == DONE);
    assign drw.rand_out = rand_q;
    assign drw.fail     = fail_q;

    a_nonzero: assert property (@(posedge Clk) disable iff (Reset) r != '0);
    a_fail_zero: assert property (@(posedge Clk) disable iff (Reset)
        (drw.valid && drw.fail) |-> (drw.rand_out == '0));
endmodule

// File: tb/tb_ghost_rng.sv
// Randomized scoreboard bench for ghost_rng plus directed corner sequences.
`timescale 1ns/1ps
module tb_ghost_rng;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'h0001;
    localparam int MAX_TRIES = 8;

    typedef struct packed {logic [3:0] r; logic f;} exp_t;

    logic Clk = 0, Reset = 1;
    logic en = 0, seed_load = 0;
    logic [15:0] seed_in = '0, state_q;
    logic en_t = 0, seed_load_t = 0;
    logic [15:0] seed_in_t = '0, state_q_t;

    ghost_rng_if #(.OUT_W(4)) bus ();
    ghost_rng_if #(.OUT_W(4)) bus_t ();

    ghost_rng #(.WIDTH(16), .TAPS(TAPS), .SEED(SEED), .OUT_W(4), .MAX_TRIES(MAX_TRIES)) dut (
        .Clk(Clk), .Reset(Reset), .en(en), .seed_load(seed_load),
        .seed_in(seed_in), .state_q(state_q), .drw(bus));

    ghost_rng #(.WIDTH(16), .TAPS(TAPS), .SEED(SEED), .OUT_W(4), .MAX_TRIES(2)) dut_t (
        .Clk(Clk), .Reset(Reset), .en(en_t), .seed_load(seed_load_t),
        .seed_in(seed_in_t), .state_q(state_q_t), .drw(bus_t));

    always #5 Clk = ~Clk;

    int checks = 0, errors = 0;
    exp_t sb[$];
    logic [15:0] m_r = SEED;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference step: shift left, append parity of tapped bits.
    function automatic logic [15:0] lfsr(input logic [15:0] v);
        int p;
        p = $countones(v & TAPS) % 2;
        return 16'((32'(v) * 2) % 65536 + p);
    endfunction

    // Whole-draw outcome from the register value at the first evaluation.
    function automatic void draw_model(input logic [15:0] r0, input int lim,
                                       output int n, output int res, output bit fl);
        logic [15:0] v;
        int c;
        v = r0; n = 0; res = 0; fl = 1;
        for (int t = 0; t < MAX_TRIES; t++) begin
            c = int'(v) % 16;
            n++;
            if (lim == 0 || c < lim) begin
                res = c; fl = 0;
                return;
            end
            v = lfsr(v);
        end
    endfunction

    task automatic adv(input bit in_draw);
        if (seed_load) m_r = (seed_in == 0) ? SEED : seed_in;
        else if (en || in_draw) m_r = lfsr(m_r);
        @(negedge Clk);
        chk("state_q", state_q, m_r);
    endtask

    task automatic do_reset();
        en = 0; seed_load = 0; bus.req = 0; bus.ready = 0; bus.limit = 0;
        Reset = 1; m_r = SEED;
        @(negedge Clk);
        chk("rst_state_q", state_q, SEED);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_fail", bus.fail, 0);
        chk("rst_rand", bus.rand_out, 0);
        Reset = 0;
    endtask

    task automatic do_draw(input int lim, input bit rnd, input int exp_res, input int hold);
        int n, res, h;
        bit fl;
        logic [15:0] r_eval;
        exp_t e;
        bus.limit = 4'(lim); bus.req = 1; bus.ready = 0; seed_load = 0;
        en = rnd ? 1'($urandom) : 1'b0;
        r_eval = en ? lfsr(m_r) : m_r;
        draw_model(r_eval, lim, n, res, fl);
        e.r = 4'(res); e.f = fl;
        sb.push_back(e);
        adv(0);
        bus.req = 0;
        for (int i = 0; i < n; i++) begin
            chk("draw_busy", bus.busy, 1);
            chk("draw_novalid", bus.valid, 0);
            if (rnd) begin en = 1'($urandom); bus.limit = 4'($urandom); bus.req = 1'($urandom); end
            adv(1);
        end
        chk("lat_valid", bus.valid, 1);
        if (exp_res >= 0) chk("dir_rand", bus.rand_out, exp_res);
        h = (hold < 0) ? int'($urandom_range(0, 4)) : hold;
        for (int k = 0; k < h; k++) begin
            bus.ready = 0; bus.req = (k % 2 == 0);
            en = rnd ? 1'($urandom) : 1'b0;
            adv(0);
            chk("done_hold", bus.valid, 1);
        end
        bus.req = 0; bus.ready = 1;
        adv(0);
        bus.ready = 0;
        chk("ret_busy", bus.busy, 0);
        chk("ret_valid", bus.valid, 0);
    endtask

    // Monitor: pops one expectation per valid rising edge, then checks hold.
    initial begin
        exp_t cur;
        bit vp;
        cur = '0; vp = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                vp = 0;
            end else begin
                if (bus.valid && !vp) begin
                    chk("sb_has_entry", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        cur = sb.pop_front();
                        chk("sb_rand", bus.rand_out, cur.r);
                        chk("sb_fail", bus.fail, cur.f);
                    end
                end else if (bus.valid) begin
                    chk("sb_rand_stable", bus.rand_out, cur.r);
                    chk("sb_fail_stable", bus.fail, cur.f);
                end
                vp = bus.valid;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 0; bus.ready = 0; bus.limit = 0;
        bus_t.req = 0; bus_t.ready = 0; bus_t.limit = 0;
        repeat (2) @(negedge Clk);
        do_reset();

        // Free run from SEED: walking one, then the bit-10 tap feeds back.
        en = 1;
        for (int i = 1; i <= 11; i++) begin
            adv(0);
            chk("freerun", state_q, (i <= 10) ? (32'd1 << i) : 32'h0801);
        end
        en = 0;

        do_reset(); do_draw(3, 0, 1, 0);
        do_reset(); do_draw(1, 0, 0, 0);
        do_reset(); do_draw(0, 0, 1, 0);

        // Zero seed substitution and load priority over en.
        do_reset();
        seed_load = 1; seed_in = 16'h0000; en = 1;
        adv(0); chk("seed_zero", state_q, 16'h0001);
        seed_in = 16'h1234;
        adv(0); chk("seed_over_en", state_q, 16'h1234);
        seed_load = 0; en = 0;

        // Seed load on the first draw cycle suppresses that evaluation.
        do_reset();
        sb.push_back(exp_t'({4'd7, 1'b0}));
        bus.limit = 8; bus.req = 1;
        adv(0);
        bus.req = 0; bus.limit = 0; seed_load = 1; seed_in = 16'h0007;
        adv(1);
        chk("sl_busy", bus.busy, 1);
        chk("sl_novalid", bus.valid, 0);
        seed_load = 0;
        adv(1);
        chk("sl_valid", bus.valid, 1);
        chk("sl_rand", bus.rand_out, 7);
        chk("sl_step", state_q, 16'h000E);
        bus.ready = 1; adv(0); bus.ready = 0;

        // Reset in the middle of a draw.
        do_reset();
        bus.limit = 1; bus.req = 1;
        adv(0);
        bus.req = 0;
        adv(1); adv(1);
        #2 Reset = 1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_valid", bus.valid, 0);
        chk("mid_rst_state", state_q, SEED);
        m_r = SEED;
        @(negedge Clk);
        Reset = 0;

        // Long DONE hold with req toggling.
        do_reset(); do_draw(3, 0, 1, 5);

        // Timeout on the two-try instance.
        do_reset();
        bus_t.limit = 1; bus_t.req = 1;
        @(negedge Clk);
        bus_t.req = 0;
        chk("to_busy", bus_t.busy, 1);
        @(negedge Clk);
        chk("to_novalid", bus_t.valid, 0);
        chk("to_state1", state_q_t, 16'h0002);
        @(negedge Clk);
        chk("to_valid", bus_t.valid, 1);
        chk("to_fail", bus_t.fail, 1);
        chk("to_rand", bus_t.rand_out, 0);
        chk("to_state2", state_q_t, 16'h0004);
        bus_t.ready = 1;
        @(negedge Clk);
        bus_t.ready = 0;
        chk("to_idle", bus_t.busy, 0);

        // Randomized traffic.
        do_reset();
        repeat (150) begin
            repeat ($urandom_range(0, 6)) begin
                en = 1'($urandom);
                seed_load = ($urandom % 6 == 0);
                seed_in = ($urandom % 3 == 0) ? 16'h0000 : 16'($urandom);
                bus.ready = 1'($urandom); bus.req = 0;
                adv(0);
            end
            seed_load = 0; bus.ready = 0;
            do_draw(($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 15)), 1, -1, -1);
        end

        repeat (3) @(negedge Clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
